// File: rtl/ip_addr_checksum_rewrite.sv
// ip_addr_checksum_rewrite
//   Overwrites the low 16 bits of the IPv4 destination address (bytes 32-33,
//   beat 1 TDATA[255:240]) with a programmed value. The header checksum
//   (beat 0 TDATA[63:48]) is patched incrementally as ~(~HC + ~m + m').
//   The checksum travels ahead of the address, so beat 0 is parked in a hold
//   register until beat 1 arrives. This costs one bubble per packet.
//
// Ports
//   AXI_ACLK, AXI_RESETN      clock, async active-low reset
//   S_AXIS_*                  input stream (TDATA/TSTRB/TUSER/TVALID/TREADY/TLAST)
//   M_AXIS_*                  output stream, registered
//   rewrite_en                enable; sampled when beat 0 is accepted
//   new_low_ip_addr           replacement bytes 32-33; sampled with beat 0
//   rewrite_count             packets rewritten (wrapping)
//
// Only 256-bit data is supported. Slave and master widths must match.
module ip_addr_checksum_rewrite #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESETN,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  input  logic                              S_AXIS_TLAST,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY,
  output logic                              M_AXIS_TLAST,
  input  logic                              rewrite_en,
  input  logic [15:0]                       new_low_ip_addr,
  output logic [31:0]                       rewrite_count
);

  localparam int DW = C_M_AXIS_DATA_WIDTH;
  localparam int UW = C_M_AXIS_TUSER_WIDTH;

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [DW/8-1:0] strb;
    logic [UW-1:0]   user;
    logic            last;
  } beat_t;

  typedef enum logic [1:0] {S_HDR0, S_HDR1, S_FLUSH, S_BODY} state_t;

  state_t      state, state_nxt;
  beat_t       or_q, or_nxt, h_q, h_nxt, s_beat;
  logic        or_vld, or_load, or_push;
  logic        h_ld, lat, cnt_inc, s_rdy, s_acc;
  logic        en_q, qual_q;
  logic [15:0] mnew_q;

  assign s_beat  = '{data: S_AXIS_TDATA, strb: S_AXIS_TSTRB,
                     user: S_AXIS_TUSER, last: S_AXIS_TLAST};
  assign or_load = !or_vld || M_AXIS_TREADY;
  assign s_acc   = S_AXIS_TVALID && s_rdy;

  // Incremental checksum patch (RFC 1624 eqn. 3). Three 16-bit terms fit
  // in 18 bits. After the first end-around fold the value is at most
  // 0x10001, so a second fold cannot carry again.
  logic [15:0] m_old, hc, hc_new, fold2;
  logic [17:0] csum_sum;
  logic [16:0] fold1;
  logic        do_rw, chg;

  assign m_old    = S_AXIS_TDATA[255:240];
  assign hc       = h_q.data[63:48];
  assign csum_sum = {2'b00, ~hc} + {2'b00, ~m_old} + {2'b00, mnew_q};
  assign fold1    = {1'b0, csum_sum[15:0]} + {15'b0, csum_sum[17:16]};
  assign fold2    = fold1[15:0] + {15'b0, fold1[16]};
  assign hc_new   = ~fold2;
  assign do_rw    = en_q && qual_q && (S_AXIS_TSTRB[31:30] == 2'b11);
  assign chg      = do_rw && (mnew_q != m_old);

  always_comb begin
    state_nxt = state;
    s_rdy     = 1'b0;
    or_push   = 1'b0;
    or_nxt    = h_q;
    h_ld      = 1'b0;
    h_nxt     = s_beat;
    lat       = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      S_HDR0: begin
        s_rdy = or_load;
        if (s_acc) begin
          if (S_AXIS_TLAST) begin
            // Single-beat packet: no address bytes to patch.
            or_push = 1'b1;
            or_nxt  = s_beat;
          end else begin
            h_ld      = 1'b1;
            lat       = 1'b1;
            state_nxt = S_HDR1;
          end
        end
      end
      S_HDR1: begin
        s_rdy = or_load;
        if (s_acc) begin
          or_push = 1'b1;
          h_ld    = 1'b1;
          if (chg) begin
            or_nxt.data[63:48]  = hc_new;
            h_nxt.data[255:240] = mnew_q;
          end
          // A matching value still counts as rewritten.
          cnt_inc   = do_rw;
          state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (or_load) begin
          or_push   = 1'b1;
          state_nxt = h_q.last ? S_HDR0 : S_BODY;
        end
      end
      S_BODY: begin
        s_rdy = or_load;
        if (s_acc) begin
          or_push = 1'b1;
          or_nxt  = s_beat;
          if (S_AXIS_TLAST) state_nxt = S_HDR0;
        end
      end
      default: state_nxt = S_HDR0;
    endcase
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      state         <= S_HDR0;
      or_vld        <= 1'b0;
      or_q          <= '0;
      h_q           <= '0;
      en_q          <= 1'b0;
      qual_q        <= 1'b0;
      mnew_q        <= '0;
      rewrite_count <= '0;
    end else begin
      state <= state_nxt;
      if (or_load) or_vld <= or_push;
      if (or_push) or_q <= or_nxt;
      if (h_ld)    h_q  <= h_nxt;
      if (lat) begin
        en_q   <= rewrite_en;
        mnew_q <= new_low_ip_addr;
        qual_q <= (S_AXIS_TDATA[159:144] == 16'h0800) &&
                  (S_AXIS_TDATA[143:136] == 8'h45);
      end
      if (cnt_inc) rewrite_count <= rewrite_count + 32'd1;
    end
  end

  assign S_AXIS_TREADY = s_rdy;
  assign M_AXIS_TVALID = or_vld;
  assign M_AXIS_TDATA  = or_q.data;
  assign M_AXIS_TSTRB  = or_q.strb;
  assign M_AXIS_TUSER  = or_q.user;
  assign M_AXIS_TLAST  = or_q.last;

endmodule

// File: tb/tb_ip_addr_checksum_rewrite.sv
// Scoreboard bench for ip_addr_checksum_rewrite. The stimulus pushes the
// expected beats for each packet. A negedge monitor pops one expected beat
// per output handshake and compares it. It also checks that output data
// stays stable while the output is stalled.
module tb_ip_addr_checksum_rewrite;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  strb;
    logic [127:0] user;
    logic         last;
  } beat_t;

  logic         AXI_ACLK = 1'b0;
  logic         AXI_RESETN = 1'b0;
  logic [255:0] S_AXIS_TDATA = '0;
  logic [31:0]  S_AXIS_TSTRB = '0;
  logic [127:0] S_AXIS_TUSER = '0;
  logic         S_AXIS_TVALID = 1'b0;
  logic         S_AXIS_TREADY;
  logic         S_AXIS_TLAST = 1'b0;
  logic [255:0] M_AXIS_TDATA;
  logic [31:0]  M_AXIS_TSTRB;
  logic [127:0] M_AXIS_TUSER;
  logic         M_AXIS_TVALID;
  logic         M_AXIS_TREADY = 1'b1;
  logic         M_AXIS_TLAST;
  logic         rewrite_en = 1'b0;
  logic [15:0]  new_low_ip_addr = '0;
  logic [31:0]  rewrite_count;

  ip_addr_checksum_rewrite dut (
    .AXI_ACLK(AXI_ACLK), .AXI_RESETN(AXI_RESETN),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TSTRB(S_AXIS_TSTRB),
    .S_AXIS_TUSER(S_AXIS_TUSER), .S_AXIS_TVALID(S_AXIS_TVALID),
    .S_AXIS_TREADY(S_AXIS_TREADY), .S_AXIS_TLAST(S_AXIS_TLAST),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB),
    .M_AXIS_TUSER(M_AXIS_TUSER), .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TLAST(M_AXIS_TLAST),
    .rewrite_en(rewrite_en), .new_low_ip_addr(new_low_ip_addr),
    .rewrite_count(rewrite_count)
  );

  always #5 AXI_ACLK = ~AXI_ACLK;

  int    checks = 0, failures = 0;
  int    exp_cnt = 0;
  bit    mon_en = 1'b0;
  bit    rand_rdy = 1'b0;
  beat_t exp_q[$];
  beat_t pkt[$];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Output backpressure: random or always ready.
  always @(posedge AXI_ACLK) begin
    #1;
    M_AXIS_TREADY = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor / scoreboard.
  bit           stalled = 1'b0;
  logic [255:0] hold_d;
  logic         hold_l;
  always @(negedge AXI_ACLK) begin
    beat_t got, e;
    if (!mon_en) stalled = 1'b0;
    else begin
      if (stalled) begin
        checks++;
        if (!M_AXIS_TVALID || M_AXIS_TDATA !== hold_d || M_AXIS_TLAST !== hold_l) begin
          failures++;
          $display("FAIL stall_stable: got v=%b last=%b data=%h expected v=1 last=%b data=%h",
                   M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, hold_l, hold_d);
        end
      end
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        got = '{data: M_AXIS_TDATA, strb: M_AXIS_TSTRB, user: M_AXIS_TUSER, last: M_AXIS_TLAST};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat: got data=%h last=%b expected no beat", got.data, got.last);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL beat: got data=%h strb=%h user=%h last=%b expected data=%h strb=%h user=%h last=%b",
                     got.data, got.strb, got.user, got.last, e.data, e.strb, e.user, e.last);
          end
        end
      end
      stalled = M_AXIS_TVALID && !M_AXIS_TREADY;
      hold_d  = M_AXIS_TDATA;
      hold_l  = M_AXIS_TLAST;
    end
  end

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference checksum update: one's-complement sum folded until it fits.
  function automatic logic [15:0] csum_upd(input logic [15:0] hc, input logic [15:0] m_old,
                                           input logic [15:0] m_new);
    logic [15:0] nh, nm;
    int unsigned s;
    nh = ~hc;
    nm = ~m_old;
    s  = nh + nm + m_new;
    while ((s >> 16) != 0) s = (s & 32'hffff) + (s >> 16);
    return ~s[15:0];
  endfunction

  // Build a packet of nb beats.
  // kind: 0 qualifying IPv4, 1 ARP ethertype, 2 IHL != 5, 3 partial strobe on beat 1.
  task automatic gen_pkt(input int nb, input int kind);
    beat_t b;
    pkt.delete();
    for (int i = 0; i < nb; i++) begin
      b.data = rnd256();
      b.strb = 32'hffff_ffff;
      b.user = {$urandom, $urandom, $urandom, $urandom};
      b.last = (i == nb - 1);
      if (i == 0) begin
        b.data[159:144] = (kind == 1) ? 16'h0806 : 16'h0800;
        b.data[143:136] = (kind == 2) ? 8'h46 : 8'h45;
      end
      if (i == 1 && kind == 3) b.strb[31:30] = 2'($urandom_range(0, 2));
      if (i >= 2) b.strb = $urandom;
      pkt.push_back(b);
    end
  endtask

  // Reference model: what the output stream should be for pkt.
  task automatic push_model(input bit en, input logic [15:0] mn);
    beat_t b0, b1;
    bit    dorw;
    dorw = en && pkt.size() >= 2 && pkt[0].data[159:144] == 16'h0800 &&
           pkt[0].data[143:136] == 8'h45 && pkt[1].strb[31:30] == 2'b11;
    if (dorw) exp_cnt++;
    for (int i = 0; i < pkt.size(); i++) begin
      b0 = pkt[i];
      if (dorw && pkt[1].data[255:240] != mn) begin
        if (i == 0) b0.data[63:48] = csum_upd(pkt[0].data[63:48], pkt[1].data[255:240], mn);
        if (i == 1) b0.data[255:240] = mn;
      end
      exp_q.push_back(b0);
    end
    b1 = b0;
  endtask

  task automatic send_beat(input beat_t b);
    bit ok;
    S_AXIS_TDATA  = b.data;
    S_AXIS_TSTRB  = b.strb;
    S_AXIS_TUSER  = b.user;
    S_AXIS_TLAST  = b.last;
    S_AXIS_TVALID = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge AXI_ACLK);
      ok = S_AXIS_TREADY;
    end
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout: got no S_AXIS_TREADY expected acceptance within 2000 cycles");
      $fatal(1, "input stalled");
    end
    @(posedge AXI_ACLK);
    #1;
  endtask

  task automatic send_pkt(input bit en, input logic [15:0] mn, input bit gaps);
    rewrite_en      = en;
    new_low_ip_addr = mn;
    for (int i = 0; i < pkt.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        S_AXIS_TVALID = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge AXI_ACLK);
        #1;
      end
      send_beat(pkt[i]);
    end
    S_AXIS_TVALID = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(posedge AXI_ACLK);
    repeat (3) @(posedge AXI_ACLK);
    #1;
    chk({nm, "_drain"}, 256'(exp_q.size()), 256'd0);
    chk({nm, "_count"}, 256'(rewrite_count), 256'(exp_cnt));
  endtask

  // Packet from the worked example: checksum b861, address c0a8.00c7.
  task automatic build_ref_pkt();
    beat_t b;
    pkt.delete();
    b.data          = rnd256();
    b.data[159:144] = 16'h0800;
    b.data[143:0]   = 144'h4500_0073_0000_4000_4011_b861_c0a8_0001_c0a8;
    b.strb          = 32'hffff_ffff;
    b.user          = {$urandom, $urandom, $urandom, $urandom};
    b.last          = 1'b0;
    pkt.push_back(b);
    b.data            = rnd256();
    b.data[255:240]   = 16'h00c7;
    b.user            = {$urandom, $urandom, $urandom, $urandom};
    b.last            = 1'b1;
    pkt.push_back(b);
  endtask

  // Expected output for the worked example rewritten to 0001 (hand-computed).
  task automatic push_ref_rewritten();
    beat_t e;
    e = pkt[0]; e.data[63:48]   = 16'hB927; exp_q.push_back(e);
    e = pkt[1]; e.data[255:240] = 16'h0001; exp_q.push_back(e);
    exp_cnt++;
  endtask

  task automatic push_unchanged();
    for (int i = 0; i < pkt.size(); i++) exp_q.push_back(pkt[i]);
  endtask

  initial begin
    logic [15:0] mn;
    // Reset state
    repeat (3) @(posedge AXI_ACLK);
    @(negedge AXI_ACLK);
    chk("rst_tvalid", 256'(M_AXIS_TVALID), 256'd0);
    chk("rst_tdata", M_AXIS_TDATA, 256'd0);
    chk("rst_tlast_strb_user", {M_AXIS_TLAST, M_AXIS_TSTRB, M_AXIS_TUSER}, 256'd0);
    chk("rst_count", 256'(rewrite_count), 256'd0);
    AXI_RESETN = 1'b1;
    @(posedge AXI_ACLK);
    #1;
    mon_en = 1'b1;

    // 1: worked example rewrite
    build_ref_pkt();
    push_ref_rewritten();
    send_pkt(1'b1, 16'h0001, 1'b0);
    drain("t1");

    // 2: same value: unchanged but counted
    push_unchanged();
    exp_cnt++;
    send_pkt(1'b1, 16'h00c7, 1'b0);
    drain("t2");

    // 3: disabled, then ARP ethertype
    push_unchanged();
    send_pkt(1'b0, 16'h0001, 1'b0);
    pkt[0].data[159:144] = 16'h0806;
    push_unchanged();
    send_pkt(1'b1, 16'h0001, 1'b0);
    drain("t3");

    // 4: single-beat packet followed by a normal rewrite
    gen_pkt(1, 0);
    push_model(1'b1, 16'h1234);
    send_pkt(1'b1, 16'h1234, 1'b0);
    build_ref_pkt();
    push_ref_rewritten();
    send_pkt(1'b1, 16'h0001, 1'b0);
    drain("t4");

    // 5: 4-beat IPv4 with random output backpressure
    rand_rdy = 1'b1;
    gen_pkt(4, 0);
    mn = pkt[1].data[255:240] ^ 16'h00ff;
    push_model(1'b1, mn);
    send_pkt(1'b1, mn, 1'b0);
    drain("t5");

    // Random mix
    for (int n = 0; n < 40; n++) begin
      bit en;
      gen_pkt($urandom_range(1, 5), $urandom_range(0, 3));
      en = ($urandom_range(0, 3) != 0);
      mn = $urandom;
      if (pkt.size() >= 2 && $urandom_range(0, 4) == 0) mn = pkt[1].data[255:240];
      push_model(en, mn);
      send_pkt(en, mn, 1'b1);
    end
    drain("rand");
    rand_rdy = 1'b0;

    // 6: reset while the held beat is being flushed
    repeat (2) @(posedge AXI_ACLK);
    #1;
    mon_en = 1'b0;
    gen_pkt(4, 0);
    rewrite_en      = 1'b1;
    new_low_ip_addr = pkt[1].data[255:240] ^ 16'h8001;
    send_beat(pkt[0]);
    send_beat(pkt[1]);
    AXI_RESETN    = 1'b0;
    S_AXIS_TVALID = 1'b0;
    #1;
    chk("flush_rst_tvalid", 256'(M_AXIS_TVALID), 256'd0);
    chk("flush_rst_count", 256'(rewrite_count), 256'd0);
    repeat (2) @(posedge AXI_ACLK);
    #1;
    AXI_RESETN = 1'b1;
    exp_cnt    = 0;
    @(posedge AXI_ACLK);
    #1;
    mon_en = 1'b1;
    build_ref_pkt();
    push_ref_rewritten();
    send_pkt(1'b1, 16'h0001, 1'b0);
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ip_addr_checksum_rewrite.md
Name: ip_addr_checksum_rewrite

Overview:
Stream-side writer for the low 16 bits of the IPv4 destination address. Each IPv4 packet entering on the slave AXI stream has its destination-address bytes 32-33 (beat 1, TDATA[255:240]) overwritten with a programmed value. The IPv4 header checksum (beat 0, TDATA[63:48]) is updated incrementally per RFC 1624. The block sits in the output-port-lookup pipeline, upstream of the field extractor that reads the same bytes. Beat 0 is held until beat 1 arrives, because the checksum precedes the address in the stream.

Parameters:
C_M_AXIS_DATA_WIDTH, 256, master data width; only 256 is supported.
C_S_AXIS_DATA_WIDTH, 256, slave data width; must equal C_M_AXIS_DATA_WIDTH.
C_M_AXIS_TUSER_WIDTH, 128, master TUSER width.
C_S_AXIS_TUSER_WIDTH, 128, slave TUSER width; must equal C_M_AXIS_TUSER_WIDTH.

Ports:
AXI_ACLK  in  1  clock.
AXI_RESETN  in  1  reset; asynchronous, active-low.
S_AXIS_TDATA  in  256  slave data; byte k occupies bits [255-8k:248-8k].
S_AXIS_TSTRB  in  32  slave byte strobes; bit 31 corresponds to byte 0.
S_AXIS_TUSER  in  128  slave sideband metadata.
S_AXIS_TVALID  in  1  slave valid.
S_AXIS_TREADY  out  1  slave ready.
S_AXIS_TLAST  in  1  slave end of packet.
M_AXIS_TDATA  out  256  master data.
M_AXIS_TSTRB  out  32  master byte strobes.
M_AXIS_TUSER  out  128  master sideband metadata.
M_AXIS_TVALID  out  1  master valid.
M_AXIS_TREADY  in  1  master ready.
M_AXIS_TLAST  out  1  master end of packet.
rewrite_en  in  1  enables rewriting; sampled when beat 0 is accepted.
new_low_ip_addr  in  16  replacement value for destination-address bytes 32-33; sampled when beat 0 is accepted.
rewrite_count  out  32  number of packets rewritten; wraps on overflow.

Behaviour:
- Storage: one output register (OR), driving M_AXIS_*, plus one hold register (H).
- OR may load when M_AXIS_TVALID=0 or M_AXIS_TREADY=1.
- TUSER and TSTRB travel unchanged with their beat.
- Reset (asynchronous, any cycle, including mid-packet): state=S_HDR0; OR and H are invalid and their contents discarded; M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA/TSTRB/TUSER=0, rewrite_count=0. The first beat accepted after reset is treated as beat 0.
- S_HDR0:
  - S_AXIS_TREADY = OR loadable.
  - On accept with TLAST=1: beat goes to OR unchanged; stay in S_HDR0.
  - On accept with TLAST=0: beat goes to H. Latch rewrite_en, new_low_ip_addr (m'), and qual.
  - qual = TDATA[159:144]==16'h0800 && TDATA[143:136]==8'h45.
  - Go to S_HDR1.
- S_HDR1:
  - S_AXIS_TREADY = OR loadable.
  - On accept of beat 1, do = latched rewrite_en && qual && TSTRB[31:30]==2'b11.
  - Let m = beat 1 TDATA[255:240] and HC = H[63:48].
  - If do && m'!=m:
    - HC' = ~fold(~HC + ~m + m'), computed as an 18-bit sum with two end-around-carry folds.
    - OR <= H with [63:48]=HC'.
    - H <= beat 1 with [255:240]=m'.
    - rewrite_count++.
  - If do && m'==m: both beats are unchanged, but rewrite_count++.
  - Otherwise: both beats are unchanged and the count is not incremented.
  - Go to S_FLUSH.
- S_FLUSH:
  - S_AXIS_TREADY=0.
  - When OR is loadable, OR <= H.
  - If H.TLAST, go to S_HDR0; else go to S_BODY.
- S_BODY:
  - S_AXIS_TREADY = OR loadable; each accepted beat goes to OR unchanged.
  - On TLAST, go to S_HDR0.
- Latency:
  - Beat 0 appears one cycle after beat 1 is accepted.
  - Body beats appear one cycle after acceptance.
  - Sustained throughput is 1 beat/cycle in S_BODY; there is one bubble per packet at S_FLUSH.
- Backpressure:
  - M_AXIS_TVALID, TDATA and TLAST remain stable while TVALID=1 and TREADY=0.
  - No beat is dropped or duplicated.

Test Plan:
1. IPv4 header with TDATA beat0 bytes 14-33 = 4500 0073 0000 4000 4011 b861 c0a8 0001 c0a8 00c7; rewrite_en=1, new_low_ip_addr=16'h0001 -> out beat0 [63:48]=16'hB927, beat1 [255:240]=16'h0001, rewrite_count=1.
2. Same packet with new_low_ip_addr=16'h00c7 -> output bit-identical to input; rewrite_count=1.
3. rewrite_en=0, or ethertype 16'h0806 -> output bit-identical to input; rewrite_count=0.
4. Single-beat packet (TLAST on beat 0) -> passes unchanged with 1-cycle latency; next packet is handled normally.
5. 4-beat IPv4 packet with M_AXIS_TREADY toggling randomly each cycle -> all 4 beats in order, TLAST only on beat 3; data stable while stalled.
6. Assert AXI_RESETN=0 in S_FLUSH -> M_AXIS_TVALID=0 immediately and rewrite_count=0; after release, the next packet is rewritten correctly.
